// File: rtl/mix_col_seq.sv
`default_nettype none
// ============================================================================
// Module      : mix_col_seq
// Description : Iterative AES MixColumns engine with valid/ready handshakes,
//               COLS_PER_CYCLE columns per clock. Define MIX_COL_INV_EN to
//               enable inverse coefficients selected by inv at accept.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_col_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] mix_in,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] mix_out
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_col_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // The 2-bit counter wraps to 0 on the last BUSY cycle (step 4 truncates to 0).
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [1:0]     cnt_q;
  logic [127:0]   work_q;
  logic [127:0]   work_d;
  logic           in_ready_q;
  logic           out_valid_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, x0, x1, x2, x3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    x0 = xtime(a0); x1 = xtime(a1); x2 = xtime(a2); x3 = xtime(a3);
    return {x0 ^ x1 ^ a1 ^ a2 ^ a3,
            a0 ^ x1 ^ x2 ^ a2 ^ a3,
            a0 ^ a1 ^ x2 ^ x3 ^ a3,
            x0 ^ a0 ^ a1 ^ a2 ^ x3};
  endfunction

`ifdef MIX_COL_INV_EN
  logic inv_q;

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] p2, p4, p8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31-8*k -: 8];
      p2    = xtime(a[k]);
      p4    = xtime(p2);
      p8    = xtime(p4);
      m9[k] = p8 ^ a[k];
      mb[k] = p8 ^ p2 ^ a[k];
      md[k] = p8 ^ p4 ^ a[k];
      me[k] = p8 ^ p4 ^ p2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [31:0] col_xform(input logic [31:0] c, input logic iv);
    return iv ? mix_inv(c) : mix_fwd(c);
  endfunction
`else
  logic unused_inv;
  assign unused_inv = inv;

  function automatic logic [31:0] col_xform(input logic [31:0] c);
    return mix_fwd(c);
  endfunction
`endif

  // Columns cnt..cnt+CPC-1 are rewritten in place; the rest pass through.
  always_comb begin
    work_d = work_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
`ifdef MIX_COL_INV_EN
      work_d[{cnt_q + 2'(j), 5'd0} +: 32] = col_xform(work_q[{cnt_q + 2'(j), 5'd0} +: 32], inv_q);
`else
      work_d[{cnt_q + 2'(j), 5'd0} +: 32] = col_xform(work_q[{cnt_q + 2'(j), 5'd0} +: 32]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      work_q      <= 128'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MIX_COL_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            work_q     <= mix_in;
            cnt_q      <= 2'd0;
            state_q    <= ST_BUSY;
            in_ready_q <= 1'b0;
`ifdef MIX_COL_INV_EN
            inv_q      <= inv;
`endif
          end
        end
        ST_BUSY: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_STEP;
          if (cnt_q == CNT_LAST) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= 2'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mix_out   = work_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_col_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mix_col_seq
// Description : Scoreboard bench for mix_col_seq at COLS_PER_CYCLE 1, 2 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_col_seq;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
`ifdef MIX_COL_INV_EN
  localparam logic INV_EN = 1'b1;
`else
  localparam logic INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] mix_in    [3];
  logic         inv       [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] mix_out   [3];

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int           d;
    logic [127:0] exp;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mix_col_seq #(.COLS_PER_CYCLE(1)) u_cpc1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .mix_in(mix_in[0]), .inv(inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .mix_out(mix_out[0]));
  mix_col_seq #(.COLS_PER_CYCLE(2)) u_cpc2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .mix_in(mix_in[1]), .inv(inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .mix_out(mix_out[1]));
  mix_col_seq #(.COLS_PER_CYCLE(4)) u_cpc4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .mix_in(mix_in[2]), .inv(inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .mix_out(mix_out[2]));

  // Reference model: generic GF(2^8) multiply with circulant coefficient rows.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic iv);
    logic [7:0]   co [4];
    logic [7:0]   b;
    logic [127:0] r;
    if (iv) begin co[0] = 8'h0E; co[1] = 8'h0B; co[2] = 8'h0D; co[3] = 8'h09; end
    else    begin co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01; end
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++)
          b = b ^ gmul(co[(k - rw + 4) % 4], s[c*32 + 24 - 8*k +: 8]);
        r[c*32 + 24 - 8*rw +: 8] = b;
      end
    return r;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 2 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [127:0] data, input logic iv, output int acc);
    int t;
    t = 0;
    while (in_ready[d] !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (in_ready[d] !== 1'b1) begin
      n_chk++;
      $display("FAIL send_timeout dut=%0d in_ready=%b required 1", d, in_ready[d]);
      acc = -1;
      return;
    end
    in_valid[d] = 1'b1;
    mix_in[d]   = data;
    inv[d]      = iv;
    tick();
    acc = cyc;
    sb.push_back('{d, ref_mix(data, iv & INV_EN)});
    in_valid[d] = 1'b0;
    mix_in[d]   = {$urandom, $urandom, $urandom, $urandom};
    inv[d]      = ~iv;
  endtask

  task automatic wait_valid(input int d, input int budget, output int seen);
    int t;
    t = 0;
    while (out_valid[d] !== 1'b1 && t < budget) begin
      tick();
      t++;
    end
    seen = (out_valid[d] === 1'b1) ? cyc : -1000;
  endtask

  task automatic pop_check(input int d, input string name);
    sb_t e;
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL %s dut=%0d got %h with empty scoreboard", name, d, mix_out[d]);
      return;
    end
    e = sb.pop_front();
    if (e.d !== d || mix_out[d] !== e.exp)
      $display("FAIL %s dut=%0d got %h required %h (queued for dut %0d)", name, d, mix_out[d], e.exp, e.d);
    else n_pass++;
  endtask

  task automatic drain(input int d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (in_ready[d] !== 1'b1) $display("FAIL reset_in_ready dut=%0d got %b required 1", d, in_ready[d]);
      else n_pass++;
      n_chk++;
      if (out_valid[d] !== 1'b0) $display("FAIL reset_out_valid dut=%0d got %b required 0", d, out_valid[d]);
      else n_pass++;
      n_chk++;
      if (mix_out[d] !== 128'd0) $display("FAIL reset_mix_out dut=%0d got %h required 0", d, mix_out[d]);
      else n_pass++;
    end
  endtask

  task automatic test_vector(input int d);
    int acc, seen;
    send(d, FIPS_IN, 1'b0, acc);
    wait_valid(d, 20, seen);
    n_chk++;
    if (seen - acc !== lat_of(d))
      $display("FAIL vec_latency dut=%0d got %0d required %0d", d, seen - acc, lat_of(d));
    else n_pass++;
    n_chk++;
    if (mix_out[d] !== FIPS_OUT) $display("FAIL vec_fips dut=%0d got %h required %h", d, mix_out[d], FIPS_OUT);
    else n_pass++;
    pop_check(d, "vec_model");
    drain(d);
    n_chk++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1)
      $display("FAIL vec_release dut=%0d out_valid=%b in_ready=%b required 0/1", d, out_valid[d], in_ready[d]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc, seen, bad, t;
    logic [127:0] exp;
    send(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, acc);
    exp = sb[0].exp;
    wait_valid(0, 20, seen);
    pop_check(0, "bp_data");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      mix_in[0]   = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || mix_out[0] !== exp) bad++;
    end
    in_valid[0] = 1'b0;
    n_chk++;
    if (bad != 0) $display("FAIL bp_stall got %0d unstable cycles required 0", bad);
    else n_pass++;
    drain(0);
    n_chk++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0)
      $display("FAIL bp_release in_ready=%b out_valid=%b required 1/0", in_ready[0], out_valid[0]);
    else n_pass++;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid[0] !== 1'b0) t++;
    end
    n_chk++;
    if (t != 0) $display("FAIL bp_no_accept got %0d out_valid cycles required 0", t);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int acc, seen, t;
    sb_t dropped;
    send(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, acc);
    dropped = sb.pop_back();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || mix_out[0] !== 128'd0)
      $display("FAIL rstmid_state in_ready=%b out_valid=%b mix_out=%h required 1/0/0 (dropped %h)",
               in_ready[0], out_valid[0], mix_out[0], dropped.exp);
    else n_pass++;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid[0] !== 1'b0) t++;
    end
    n_chk++;
    if (t != 0) $display("FAIL rstmid_no_out got %0d out_valid cycles required 0", t);
    else n_pass++;
    send(0, {4{32'hc6c6c6c6}}, 1'b0, acc);
    wait_valid(0, 20, seen);
    n_chk++;
    if (mix_out[0] !== {4{32'hc6c6c6c6}} || seen - acc !== 4)
      $display("FAIL rstmid_c6 got %h lat %0d required %h lat 4", mix_out[0], seen - acc, {4{32'hc6c6c6c6}});
    else n_pass++;
    pop_check(0, "rstmid_model");
    drain(0);
  endtask

  task automatic test_inv(input int d);
    int acc, seen;
    logic [127:0] exp;
    send(d, FIPS_OUT, 1'b1, acc);
    wait_valid(d, 20, seen);
    exp = INV_EN ? FIPS_IN : FIPS_IN ^ FIPS_IN ^ sb[0].exp;
    n_chk++;
    if (mix_out[d] !== exp || seen - acc !== lat_of(d))
      $display("FAIL inv_vec dut=%0d got %h lat %0d required %h lat %0d", d, mix_out[d], seen - acc, exp, lat_of(d));
    else n_pass++;
    pop_check(d, "inv_model");
    drain(d);
`ifdef MIX_COL_INV_EN
    send(d, {4{32'hd5d5d7d6}}, 1'b1, acc);
    wait_valid(d, 20, seen);
    n_chk++;
    if (mix_out[d] !== {4{32'hd4d4d4d5}})
      $display("FAIL inv_col dut=%0d got %h required %h", d, mix_out[d], {4{32'hd4d4d4d5}});
    else n_pass++;
    pop_check(d, "inv_col_model");
    drain(d);
`endif
  endtask

  task automatic test_back_to_back(input int d);
    int acc_t [4];
    int got;
    out_ready[d] = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(d, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), acc_t[i]);
      end
      begin
        got = 0;
        for (int t = 0; t < 120 && got < 4; t++) begin
          tick();
          if (out_valid[d] === 1'b1) begin
            pop_check(d, "b2b_data");
            got++;
          end
        end
      end
    join
    out_ready[d] = 1'b0;
    n_chk++;
    if (got != 4) $display("FAIL b2b_count dut=%0d got %0d required 4", d, got);
    else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if (acc_t[i] - acc_t[i-1] !== lat_of(d) + 2)
        $display("FAIL b2b_period dut=%0d got %0d required %0d", d, acc_t[i] - acc_t[i-1], lat_of(d) + 2);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      mix_in[d]    = '0;
      inv[d]       = 1'b0;
      out_ready[d] = 1'b0;
    end
    test_reset();
    test_vector(0);
    test_backpressure();
    test_reset_mid();
    test_vector(1);
    test_vector(2);
    test_inv(0);
    test_inv(2);
    for (int d = 0; d < 3; d++) test_back_to_back(d);
    n_chk++;
    if (sb.size() != 0) $display("FAIL sb_leftover got %0d entries required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
